// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with synchronous load, wrap/saturate terminal
// handling, carry cascade pulse and registered active-low seven-segment bytes.
module bcd_updown_counter #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned WRAP   = 1,
  parameter int unsigned DP_POS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic [8*DIGITS-1:0]   hex,
  output logic                  carry_out,
  output logic                  load_err
);

  localparam int unsigned CW = 4 * DIGITS;
  localparam int unsigned HW = 8 * DIGITS;

  // {dp_n, g..a}, active-low; anything outside 0..9 blanks the digit
  function automatic logic [7:0] seg_byte(input logic [3:0] d, input logic dp_n);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return {dp_n, s};
  endfunction

  logic [CW-1:0] count_q, count_d, step_val;
  logic [HW-1:0] hex_q, hex_d, hex_rst;
  logic          carry_q, carry_d;
  logic          err_q, err_d;
  logic          load_ok, terminal, chain;
  logic [3:0]    dig;

  // Ripple step: a digit moves only while every lower digit sits at its limit
  always_comb begin
    step_val = count_q;
    chain    = 1'b1;
    load_ok  = 1'b1;
    dig      = 4'd0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      dig = count_q[4*i +: 4];
      if (chain) begin
        if (up) step_val[4*i +: 4] = (dig == 4'd9) ? 4'd0 : dig + 4'd1;
        else    step_val[4*i +: 4] = (dig == 4'd0) ? 4'd9 : dig - 4'd1;
      end
      chain = chain & (up ? (dig == 4'd9) : (dig == 4'd0));
      if (load_val[4*i +: 4] > 4'd9) load_ok = 1'b0;
    end
    terminal = chain;
  end

  // Next state: load beats enable; terminal step wraps or holds
  always_comb begin
    count_d = count_q;
    carry_d = 1'b0;
    err_d   = 1'b0;
    if (load) begin
      if (load_ok) count_d = load_val;
      else         err_d   = 1'b1;
    end else if (en) begin
      carry_d = terminal;
      if (!terminal || (WRAP != 0)) count_d = step_val;
    end
  end

  always_comb begin
    hex_d   = '0;
    hex_rst = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      hex_d[8*i +: 8]   = seg_byte(count_q[4*i +: 4], (i == DP_POS) ? 1'b0 : 1'b1);
      hex_rst[8*i +: 8] = seg_byte(4'd0, (i == DP_POS) ? 1'b0 : 1'b1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      hex_q   <= hex_rst;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      hex_q   <= hex_d;
      carry_q <= carry_d;
      err_q   <= err_d;
    end
  end

  assign count     = count_q;
  assign hex       = hex_q;
  assign carry_out = carry_q;
  assign load_err  = err_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Scoreboard bench driving three counter flavours (4-digit wrap, 4-digit saturate,
// 6-digit without decimal point) from one directed + random stimulus stream.
module tb_bcd_updown_counter;

  localparam int NU = 3;

  logic        clk = 1'b0;
  logic        reset, en, up, load;
  logic [31:0] lv;

  logic [15:0] cnt_a, cnt_b;
  logic [23:0] cnt_c;
  logic [31:0] hex_a, hex_b;
  logic [47:0] hex_c;
  logic        co_a, co_b, co_c, le_a, le_b, le_c;

  always #5 clk = ~clk;

  bcd_updown_counter #(.DIGITS(4), .WRAP(1), .DP_POS(3)) u_wrap (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(lv[15:0]),
    .count(cnt_a), .hex(hex_a), .carry_out(co_a), .load_err(le_a));

  bcd_updown_counter #(.DIGITS(4), .WRAP(0), .DP_POS(3)) u_sat (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(lv[15:0]),
    .count(cnt_b), .hex(hex_b), .carry_out(co_b), .load_err(le_b));

  bcd_updown_counter #(.DIGITS(6), .WRAP(1), .DP_POS(7)) u_six (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(lv[23:0]),
    .count(cnt_c), .hex(hex_c), .carry_out(co_c), .load_err(le_c));

  typedef struct {
    string       tag;
    int          unit;
    logic [31:0] cnt;
    logic [63:0] hx;
    logic        co;
    logic        le;
  } exp_t;

  exp_t sb[$];
  int   mval[NU];
  int   n_total = 0;
  int   n_pass  = 0;

  function automatic int ud(int u);  return (u == 2) ? 6 : 4; endfunction
  function automatic bit uw(int u);  return (u == 1) ? 1'b0 : 1'b1; endfunction
  function automatic int udp(int u); return (u == 2) ? 7 : 3; endfunction

  function automatic int pow10(int d);
    int r = 1;
    for (int i = 0; i < d; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [31:0] to_bcd(int v, int d);
    logic [31:0] r = '0;
    int          t = v;
    for (int i = 0; i < d; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic bit bcd_ok(logic [31:0] b, int d);
    for (int i = 0; i < d; i++) if (b[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int from_bcd(logic [31:0] b, int d);
    int r = 0;
    for (int i = d - 1; i >= 0; i--) r = r * 10 + int'(b[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [7:0] seg(logic [3:0] x, bit dp_lit);
    logic [7:0] s;
    case (x)
      4'd0: s = 8'hC0; 4'd1: s = 8'hF9; 4'd2: s = 8'hA4; 4'd3: s = 8'hB0;
      4'd4: s = 8'h99; 4'd5: s = 8'h92; 4'd6: s = 8'h82; 4'd7: s = 8'hF8;
      4'd8: s = 8'h80; 4'd9: s = 8'h90; default: s = 8'hFF;
    endcase
    if (dp_lit) s[7] = 1'b0;
    return s;
  endfunction

  function automatic logic [63:0] hex_of(int v, int u);
    logic [63:0] r  = '0;
    logic [31:0] bc = to_bcd(v, ud(u));
    for (int i = 0; i < ud(u); i++) r[8*i +: 8] = seg(bc[4*i +: 4], i == udp(u));
    return r;
  endfunction

  task automatic step(input string tag, input bit r, input bit ld, input logic [31:0] v,
                      input bit e, input bit dir);
    exp_t        x;
    exp_t        y;
    logic [31:0] ac;
    logic [63:0] ah;
    logic        aco, ale;
    int          mx;
    reset = r; load = ld; lv = v; en = e; up = dir;
    for (int u = 0; u < NU; u++) begin
      mx = pow10(ud(u)) - 1;
      x.tag = tag; x.unit = u; x.co = 1'b0; x.le = 1'b0;
      if (r) begin
        mval[u] = 0;
        x.hx    = hex_of(0, u);
      end else begin
        x.hx = hex_of(mval[u], u);
        if (ld) begin
          if (bcd_ok(v, ud(u))) mval[u] = from_bcd(v, ud(u));
          else                  x.le    = 1'b1;
        end else if (e) begin
          if (dir) begin
            if (mval[u] == mx) begin x.co = 1'b1; mval[u] = uw(u) ? 0 : mx; end
            else mval[u] = mval[u] + 1;
          end else begin
            if (mval[u] == 0) begin x.co = 1'b1; mval[u] = uw(u) ? mx : 0; end
            else mval[u] = mval[u] - 1;
          end
        end
      end
      x.cnt = to_bcd(mval[u], ud(u));
      sb.push_back(x);
    end
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      y = sb.pop_front();
      case (y.unit)
        0:       begin ac = 32'(cnt_a); ah = 64'(hex_a); aco = co_a; ale = le_a; end
        1:       begin ac = 32'(cnt_b); ah = 64'(hex_b); aco = co_b; ale = le_b; end
        default: begin ac = 32'(cnt_c); ah = 64'(hex_c); aco = co_c; ale = le_c; end
      endcase
      n_total += 4;
      assert (ac === y.cnt) n_pass++;
      else $error("FAIL %s u%0d count: got %h want %h", y.tag, y.unit, ac, y.cnt);
      assert (ah === y.hx) n_pass++;
      else $error("FAIL %s u%0d hex: got %h want %h", y.tag, y.unit, ah, y.hx);
      assert (aco === y.co) n_pass++;
      else $error("FAIL %s u%0d carry_out: got %b want %b", y.tag, y.unit, aco, y.co);
      assert (ale === y.le) n_pass++;
      else $error("FAIL %s u%0d load_err: got %b want %b", y.tag, y.unit, ale, y.le);
    end
  endtask

  initial begin
    logic [31:0] rv;
    reset = 1'b1; en = 1'b1; up = 1'b1; load = 1'b1; lv = 32'h0000_1234;
    for (int u = 0; u < NU; u++) mval[u] = 0;

    step("rst0", 1, 1, 32'h1234, 1, 1);
    step("rst1", 1, 1, 32'h1234, 1, 1);
    step("ld0999", 0, 1, 32'h0999, 0, 1);
    step("inc1000", 0, 0, 32'h0, 1, 1);
    step("hex1000", 0, 0, 32'h0, 0, 1);

    step("ld9999", 0, 1, 32'h9999, 0, 1);
    step("up_term", 0, 0, 32'h0, 1, 1);
    step("idle", 0, 0, 32'h0, 0, 1);
    step("ld0000", 0, 1, 32'h0000, 0, 0);
    step("dn_term", 0, 0, 32'h0, 1, 0);
    step("dn_more", 0, 0, 32'h0, 1, 0);

    step("ld9999b", 0, 1, 32'h9999, 0, 1);
    for (int i = 0; i < 3; i++) step("sat_hold", 0, 0, 32'h0, 1, 1);
    step("sat_dn", 0, 0, 32'h0, 1, 0);

    step("ld_bad", 0, 1, 32'h12A4, 1, 1);
    step("after_bad", 0, 0, 32'h0, 0, 1);
    step("ld_en", 0, 1, 32'h0042, 1, 1);
    step("dir_flip", 0, 0, 32'h0, 1, 0);
    step("dir_flip2", 0, 0, 32'h0, 1, 1);

    step("ld099990", 0, 1, 32'h0009_9990, 0, 1);
    for (int i = 0; i < 10; i++) step("to100000", 0, 0, 32'h0, 1, 1);
    step("hold", 0, 0, 32'h0, 0, 1);
    step("run", 0, 0, 32'h0, 1, 1);
    step("mid_rst", 1, 0, 32'h0, 1, 1);
    step("post_rst", 0, 0, 32'h0, 1, 0);

    for (int i = 0; i < 80; i++) begin
      rv = '0;
      for (int d = 0; d < 6; d++) rv[4*d +: 4] = ($urandom_range(0, 3) == 0) ? 4'd9 : 4'($urandom_range(0, 9));
      if ($urandom_range(0, 9) == 0) rv[4*$urandom_range(0, 5) +: 4] = 4'($urandom_range(10, 15));
      step("rand", $urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0, rv,
           $urandom_range(0, 4) != 0, $urandom_range(0, 2) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
